// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and helpers for the push-button conditioner.
//               Holds the per-channel FSM state encoding, the move-direction
//               indices used by the cursor tracker, and the function that
//               sizes the per-channel cycle counter.
// Macro       : BTN_AUTO_REPEAT_EN (selects the counter sizing in the users)
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_CHK = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        REL_CHK   = 3'd4
    } btn_state_t;

    // Button index doubles as the move direction code (bit 0 wins).
    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;

    // Counter must hold the largest terminal count in use; the repeat
    // timings only matter when auto-repeat is built in.
    function automatic int cnt_width(input int debounce, input int delay,
                                     input int period, input bit rep_en);
        int m;
        m = debounce;
        if (rep_en) begin
            if (delay > m)  m = delay;
            if (period > m) m = period;
        end
        return $clog2(m) + 1;
    endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_ch
// Description : One button channel: two-flop synchroniser, debounce /
//               auto-repeat FSM sharing a single counter, registered clean
//               level and single-cycle press pulse.
// Ports       : clk_i    - system clock
//               rst_ni   - synchronous active-low reset
//               btn_i    - raw asynchronous button level (active high)
//               clean_o  - debounced level (registered)
//               pulse_o  - one-cycle strobe per accepted press / repeat
// Macro       : BTN_AUTO_REPEAT_EN - adds the HELD -> REPEAT path and the
//               periodic repeat pulses; without it a press yields one pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic clean_o,
    output logic pulse_o
);

`ifdef BTN_AUTO_REPEAT_EN
    localparam bit c_rep_en = 1'b1;
`else
    localparam bit c_rep_en = 1'b0;
`endif

    localparam int c_cnt_w = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY,
                                       REPEAT_PERIOD, c_rep_en);
    typedef logic [c_cnt_w-1:0] cnt_t;

    localparam cnt_t c_deb_last = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t c_one      = cnt_t'(1);
`ifdef BTN_AUTO_REPEAT_EN
    localparam cnt_t c_dly_last = cnt_t'(REPEAT_DELAY - 1);
    localparam cnt_t c_per_last = cnt_t'(REPEAT_PERIOD - 1);
`endif

    logic [1:0] sync_q;
    logic       sync;
    btn_state_t state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       fire_q, fire_d;     // pulse event, one cycle ahead of pulse_q
    logic       clean_q, clean_d;
    logic       pulse_q, pulse_d;

    assign sync = sync_q[1];

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= 2'b00;
            state_q <= IDLE;
            cnt_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fire_q  <= fire_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync) begin
                    state_d = IDLE;
                end else if (cnt_q == c_deb_last) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    fire_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            HELD: begin
                if (!sync) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
`ifdef BTN_AUTO_REPEAT_EN
                else if (cnt_q == c_dly_last) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    fire_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
`endif
            end
`ifdef BTN_AUTO_REPEAT_EN
            REPEAT: begin
                if (!sync) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end else if (cnt_q == c_per_last) begin
                    cnt_d  = '0;
                    fire_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
`endif
            REL_CHK: begin
                // A bounce back to 1 returns to HELD without a pulse and
                // restarts the repeat timer.
                if (sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == c_deb_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        clean_d = (state_q == HELD) || (state_q == REPEAT) || (state_q == REL_CHK);
        pulse_d = fire_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            clean_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            clean_q <= clean_d;
            pulse_q <= pulse_d;
        end
    end

    assign clean_o = clean_q;
    assign pulse_o = pulse_q;

endmodule : btn_debounce_ch
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner
// Description : Push-button front end for the cursor tracker. Conditions
//               NBTN raw buttons into debounced levels and press pulses and
//               priority-encodes the pulses into a move strobe/direction.
// Ports       : CLK        - system clock
//               RESET      - synchronous active-low reset
//               PushButton - raw asynchronous button levels (active high)
//               btn_clean  - debounced level per button
//               btn_pulse  - one-cycle strobe per accepted press / repeat
//               move_valid - high while any btn_pulse bit is high
//               move_dir   - lowest pulsing index (Right > Up > Down), else 0
// Macro       : BTN_AUTO_REPEAT_EN - enables auto-repeat while a button is
//               held (default build: one pulse per press).
// Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NBTN            = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NBTN-1:0] PushButton,
    output logic [NBTN-1:0] btn_clean,
    output logic [NBTN-1:0] btn_pulse,
    output logic            move_valid,
    output logic [1:0]      move_dir
);

    for (genvar g = 0; g < NBTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk_i   (CLK),
            .rst_ni  (RESET),
            .btn_i   (PushButton[g]),
            .clean_o (btn_clean[g]),
            .pulse_o (btn_pulse[g])
        );
    end

    // Pulses are already registered, so the encoder stays combinational
    // and lines up with btn_pulse in the same cycle.
    always_comb begin
        move_valid = |btn_pulse;
        move_dir   = DIR_RIGHT;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (btn_pulse[i]) begin
                move_dir = 2'(i);
            end
        end
    end

endmodule : btn_conditioner
`default_nettype wire

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream front end for the cursor tracker. Takes raw, asynchronous, bouncing push-button levels.
- Per button, produces a synchronised, debounced level and a single-cycle press pulse, with optional auto-repeat while held.
- Also produces a priority-encoded move strobe.
- The tracker consumes the clean levels/pulses instead of sampling the pins directly.

Parameters:
- NBTN, 3, number of button channels (bit 0 Right, bit 1 Up, bit 2 Down).
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a press or release (10 ms at 100 MHz); must be >= 1.
- REPEAT_DELAY, 50000000, held cycles after the accepted press before the first repeat pulse.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses; must be >= 2.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-low reset.
- PushButton  in  NBTN  raw button levels, active high, asynchronous.
- btn_clean  out  NBTN  debounced level per button.
- btn_pulse  out  NBTN  one-cycle strobe per accepted press or repeat.
- move_valid  out  1  high for one cycle when any btn_pulse bit is high.
- move_dir  out  2  index of the highest-priority pulsing button (bit 0 highest); 0 when move_valid = 0.

Behaviour:
- Reset (RESET = 0 at a CLK edge):
  - Clears synchronisers, counters and FSMs.
  - All outputs are 0 after that edge.
  - Reset mid-press discards the press; no pulse is emitted on exit from reset even if the button is held. The button must pass a full press debounce again.
- Synchroniser: 2 flops per channel; sync = output of the second flop.
- Per-channel FSM with one counter, width clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1.
  - IDLE: clean = 0. sync = 1 → PRESS_CHK, cnt = 0.
  - PRESS_CHK: sync = 0 → IDLE. Otherwise cnt++; when cnt = DEBOUNCE_CYCLES-1 → HELD, cnt = 0.
  - HELD: clean = 1; pulse = 1 on the first cycle in HELD only. sync = 0 → REL_CHK, cnt = 0. Otherwise cnt++; when cnt = REPEAT_DELAY-1 → REPEAT, cnt = 0, and a pulse is emitted on the cycle REPEAT is entered.
  - REPEAT: clean = 1. sync = 0 → REL_CHK. Otherwise cnt++; when cnt = REPEAT_PERIOD-1, pulse for one cycle and set cnt = 0.
  - REL_CHK: clean stays 1. sync = 1 → HELD with cnt = 0 and no pulse (a bounce does not re-trigger; the repeat timer restarts). Otherwise cnt++; when cnt = DEBOUNCE_CYCLES-1 → IDLE, clean = 0.
- Latency:
  - Press: from the first CLK edge sampling PushButton = 1 to the edge at which btn_pulse rises is DEBOUNCE_CYCLES + 3 edges, provided the input is stable.
  - Release: from the first edge sampling 0 to btn_clean falling is DEBOUNCE_CYCLES + 3 edges.
- Outputs are registered. btn_pulse is never high on two consecutive cycles for the same channel.
- Channels are fully independent.
- Simultaneous pulses: all btn_pulse bits assert. move_valid = 1; move_dir = lowest set index (Right > Up > Down), matching the tracker's priority.
- A glitch shorter than DEBOUNCE_CYCLES in either direction produces no output change.

Optional Feature:
- BTN_AUTO_REPEAT_EN.
- Defined: the HELD → REPEAT path and the periodic pulses are present, as described above.
- Undefined: HELD never leaves except to REL_CHK; there is exactly one pulse per accepted press. REPEAT_DELAY and REPEAT_PERIOD are ignored, and the counter is sized by DEBOUNCE_CYCLES only.

Decomposition:
- Package btn_pkg:
  - FSM state enum (IDLE, PRESS_CHK, HELD, REPEAT, REL_CHK).
  - Direction index constants DIR_RIGHT = 0, DIR_UP = 1, DIR_DOWN = 2.
  - Counter-width function.
- Sub-module btn_debounce_ch: one channel (synchroniser, FSM, counter, clean/pulse).
- Top level instantiates NBTN channels via generate and contains the priority encoder for move_valid/move_dir.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 8, BTN_AUTO_REPEAT_EN defined.
- Clean press: PushButton[0] rises and is held 10 cycles → btn_pulse[0] high exactly 1 cycle, 7 edges after the rise; btn_clean[0] = 1; move_valid = 1, move_dir = 0.
- Bounce rejection: PushButton[1] toggles 1,0,1,0 every 2 cycles, then stays 0 → no pulse, btn_clean[1] stays 0. Then a 3-cycle release glitch while held → btn_clean stays 1, no extra pulse.
- Auto-repeat: hold PushButton[2] for 60 cycles after acceptance → pulses at hold-cycle offsets 0, 20, 28, 36, 44, 52. Then release → btn_clean[2] falls 7 edges after release.
- Simultaneous: PushButton = 3'b110 rising on the same edge → btn_pulse = 3'b110, move_dir = 1.
- Reset mid-press: RESET = 0 for 1 cycle during PRESS_CHK, with PushButton[0] held → all outputs 0; a pulse appears only after a full 7-edge debounce following reset release.
- Macro undefined: hold for 60 cycles → exactly one pulse.
